// File: rtl/dso_rd_unpack_256to8.sv
// Read-side unpacker: pops wide words from a first-word-fall-through FIFO and
// serialises them LSB-first into a framed OUT_WIDTH sample stream.
module dso_rd_unpack_256to8 #(
   parameter int IN_WIDTH  = 256,
   parameter int OUT_WIDTH = 8,
   parameter int FRAME_LEN = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_vld,
   output logic                 in_rd_en,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic                 out_sof,
   output logic                 out_last,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int NB    = IN_WIDTH / OUT_WIDTH;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NB - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                          state, state_nx;
   logic [NB-1:0][OUT_WIDTH-1:0]    word_buf;
   logic                            buf_full;
   logic [IDX_W-1:0]                byte_idx;
   logic [CNT_W-1:0]                sample_cnt;
   logic                            accept, wrap, frame_end;

   assign busy     = (state == RUN);
   assign out_vld  = busy & buf_full;
   assign out_data = word_buf[byte_idx];
   assign out_sof  = out_vld & (sample_cnt == '0);
   assign out_last = out_vld & (sample_cnt == CNT_LAST);
   assign accept   = out_vld & out_rdy;
   assign wrap     = accept & (byte_idx == IDX_MAX) & ~out_last;

   // Refill either an empty buffer or in the same cycle the last byte leaves,
   // so consecutive words stream without a bubble.
   assign in_rd_en = busy & in_vld & ~abort & (~buf_full | wrap);

   always_comb begin
      state_nx  = state;
      frame_end = 1'b0;
      case (state)
         IDLE: if (start && !abort) state_nx = RUN;
         RUN: begin
            if (abort || (accept && out_last)) begin
               state_nx  = IDLE;
               frame_end = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_buf   <= '0;
         buf_full   <= 1'b0;
         byte_idx   <= '0;
         sample_cnt <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         frame_done <= frame_end;
         if (state == IDLE) begin
            if (start && !abort) begin
               buf_full   <= 1'b0;
               byte_idx   <= '0;
               sample_cnt <= '0;
            end
         end else if (frame_end) begin
            // End of frame: remaining bytes of the current word are dropped.
            buf_full   <= 1'b0;
            byte_idx   <= '0;
            sample_cnt <= '0;
         end else begin
            if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
            if (in_rd_en) begin
               word_buf <= in_data;
               buf_full <= 1'b1;
               byte_idx <= '0;
            end else if (wrap) begin
               buf_full <= 1'b0;
               byte_idx <= '0;
            end else if (accept) begin
               byte_idx <= byte_idx + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_dso_rd_unpack_256to8.sv
// Bench for dso_rd_unpack_256to8: two instances (whole-word and partial-word
// frame lengths) fed from queue FIFO models and checked against a frame model.
module tb_dso_rd_unpack_256to8;

   localparam int NB  = 32;
   localparam int FL0 = 64;
   localparam int FL1 = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic         start_s[2], abort_s[2], in_vld_s[2], in_rd_en_s[2];
   logic         out_vld_s[2], out_rdy_s[2], out_sof_s[2], out_last_s[2];
   logic         busy_s[2], done_s[2];
   logic [255:0] in_data_s[2];
   logic [7:0]   out_data_s[2];

   always #5 clk = ~clk;

   dso_rd_unpack_256to8 #(.IN_WIDTH(256), .OUT_WIDTH(8), .FRAME_LEN(FL0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
      .in_data(in_data_s[0]), .in_vld(in_vld_s[0]), .in_rd_en(in_rd_en_s[0]),
      .out_data(out_data_s[0]), .out_vld(out_vld_s[0]), .out_rdy(out_rdy_s[0]),
      .out_sof(out_sof_s[0]), .out_last(out_last_s[0]), .busy(busy_s[0]),
      .frame_done(done_s[0]));

   dso_rd_unpack_256to8 #(.IN_WIDTH(256), .OUT_WIDTH(8), .FRAME_LEN(FL1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
      .in_data(in_data_s[1]), .in_vld(in_vld_s[1]), .in_rd_en(in_rd_en_s[1]),
      .out_data(out_data_s[1]), .out_vld(out_vld_s[1]), .out_rdy(out_rdy_s[1]),
      .out_sof(out_sof_s[1]), .out_last(out_last_s[1]), .busy(busy_s[1]),
      .frame_done(done_s[1]));

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Frame model: a frame is the first FRAME_LEN bytes of the words popped
   // since its start; a pop is due whenever the sink is about to run dry.
   bit           m_busy[2], m_done[2];
   int           m_cnt[2];
   logic [255:0] fifo[2][$];
   logic [255:0] popped[2][$];
   int           gap_left[2], rdy_pct[2], vld_pct[2];
   int           fv_cyc[2], last_acc_cyc[2];
   logic [7:0]   first_d[2], last_d[2];
   logic [7:0]   seq = 8'h00;

   typedef struct {
      int inst; bit clr; int npush; bit rnd; int rp; int vp; bit gap;
      int exp_n; int exp_pops; int exp_first; int exp_last;
   } vec_t;
   vec_t tbl[8];

   function automatic int fl(input int k);
      return (k == 0) ? FL0 : FL1;
   endfunction

   function automatic int nwords(input int k);
      return (fl(k) + NB - 1) / NB;
   endfunction

   function automatic string nm(input string s, input int k);
      return $sformatf("%s%0d", s, k);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk(nm({tag, "_vld"}, k),   out_vld_s[k],  1'b0);
         chk(nm({tag, "_data"}, k),  out_data_s[k], 8'h00);
         chk(nm({tag, "_sof"}, k),   out_sof_s[k],  1'b0);
         chk(nm({tag, "_last"}, k),  out_last_s[k], 1'b0);
         chk(nm({tag, "_busy"}, k),  busy_s[k],     1'b0);
         chk(nm({tag, "_done"}, k),  done_s[k],     1'b0);
         chk(nm({tag, "_rd_en"}, k), in_rd_en_s[k], 1'b0);
      end
   endtask

   task automatic push_words(input int k, input int n, input bit rnd);
      logic [255:0] w;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < NB; b++) begin
            if (rnd) w[8*b +: 8] = 8'($urandom);
            else begin
               w[8*b +: 8] = seq;
               seq = seq + 8'd1;
            end
         end
         fifo[k].push_back(w);
      end
   endtask

   // One clock cycle: drive at the falling edge, check, then advance the model.
   task automatic tick();
      bit ab[2], st[2], accd[2], popd[2];
      logic [7:0] dd[2];
      for (int k = 0; k < 2; k++) begin
         bit gap_on;
         gap_on = (gap_left[k] > 0) && m_busy[k] && (m_cnt[k] >= NB - 1);
         if (gap_on) gap_left[k]--;
         in_vld_s[k]  = (fifo[k].size() > 0) && !gap_on && ($urandom_range(99) < vld_pct[k]);
         in_data_s[k] = (fifo[k].size() > 0) ? fifo[k][0] : '0;
         out_rdy_s[k] = ($urandom_range(99) < rdy_pct[k]);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         int idx, np;
         bit have, acc_m, need;
         logic [255:0] w;
         idx  = m_cnt[k];
         np   = popped[k].size();
         have = m_busy[k] && (np > idx / NB);
         chk(nm("busy", k), busy_s[k], m_busy[k]);
         chk(nm("frame_done", k), done_s[k], m_done[k]);
         chk(nm("out_vld", k), out_vld_s[k], have);
         if (have && out_vld_s[k]) begin
            w = popped[k][idx / NB];
            chk(nm("out_data", k), out_data_s[k], w[8*(idx % NB) +: 8]);
            chk(nm("out_sof", k), out_sof_s[k], idx == 0);
            chk(nm("out_last", k), out_last_s[k], idx == fl(k) - 1);
            if (fv_cyc[k] < 0) fv_cyc[k] = cyc;
         end
         acc_m = have && out_rdy_s[k];
         need  = m_busy[k] && in_vld_s[k] && !abort_s[k] && (np < nwords(k)) &&
                 (idx + int'(acc_m) >= np * NB);
         chk(nm("in_rd_en", k), in_rd_en_s[k], need);
         ab[k]   = abort_s[k];
         st[k]   = start_s[k];
         accd[k] = out_vld_s[k] && out_rdy_s[k];
         popd[k] = in_rd_en_s[k];
         dd[k]   = out_data_s[k];
      end
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (popd[k] && fifo[k].size() > 0) popped[k].push_back(fifo[k].pop_front());
         m_done[k] = 1'b0;
         if (m_busy[k]) begin
            if (ab[k]) begin
               m_busy[k] = 1'b0;
               m_done[k] = 1'b1;
            end else if (accd[k]) begin
               if (m_cnt[k] == 0) first_d[k] = dd[k];
               last_d[k] = dd[k];
               last_acc_cyc[k] = cyc - 1;
               m_cnt[k]++;
               if (m_cnt[k] == fl(k)) begin
                  m_busy[k] = 1'b0;
                  m_done[k] = 1'b1;
               end
            end
         end else if (st[k] && !ab[k]) begin
            m_busy[k] = 1'b1;
            m_cnt[k]  = 0;
            popped[k].delete();
         end
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         start_s[k] = 1'b0;
         abort_s[k] = 1'b0;
      end
   endtask

   task automatic run_frame(input vec_t v);
      int k, t0;
      k = v.inst;
      if (v.clr) begin
         fifo[k].delete();
         seq = 8'h00;
      end
      push_words(k, v.npush, v.rnd);
      rdy_pct[k]  = v.rp;
      vld_pct[k]  = v.vp;
      gap_left[k] = v.gap ? 5 : 0;
      fv_cyc[k]   = -1;
      t0 = cyc;
      start_s[k] = 1'b1;
      tick();
      for (int n = 0; n < 3000 && m_busy[k]; n++) tick();
      if (m_busy[k]) begin
         checks++;
         errors++;
         $display("FAIL timeout%0d: frame still running after 3000 cycles", k);
      end
      tick();
      chk(nm("samples", k), m_cnt[k], v.exp_n);
      chk(nm("pops", k), popped[k].size(), v.exp_pops);
      if (v.vp == 100) chk(nm("latency", k), fv_cyc[k] - t0, 2);
      if (v.rp == 100 && v.vp == 100 && !v.gap)
         chk(nm("no_bubble", k), last_acc_cyc[k] - fv_cyc[k] + 1, v.exp_n);
      if (v.exp_first >= 0) begin
         chk(nm("first_sample", k), first_d[k], v.exp_first);
         chk(nm("last_sample", k), last_d[k], v.exp_last);
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         start_s[k] = 1'b0; abort_s[k] = 1'b0; in_vld_s[k] = 1'b0;
         out_rdy_s[k] = 1'b0; in_data_s[k] = '0;
         m_busy[k] = 1'b0; m_done[k] = 1'b0; m_cnt[k] = 0;
         gap_left[k] = 0; rdy_pct[k] = 100; vld_pct[k] = 100;
         fv_cyc[k] = -1; last_acc_cyc[k] = 0; first_d[k] = '0; last_d[k] = '0;
      end
      //             inst clr push rnd rdy vld gap  n  pops first last
      tbl[0] = '{0, 1, 2, 0, 100, 100, 0, 64, 2, 'h00, 'h3F};
      tbl[1] = '{1, 1, 3, 0, 100, 100, 0, 40, 2, 'h00, 'h27};
      tbl[2] = '{1, 0, 1, 0, 100, 100, 0, 40, 2, 'h40, 'h67};
      tbl[3] = '{0, 1, 2, 1,  30, 100, 0, 64, 2, -1, -1};
      tbl[4] = '{1, 1, 2, 1,  30, 100, 0, 40, 2, -1, -1};
      tbl[5] = '{0, 1, 2, 0, 100, 100, 1, 64, 2, 'h00, 'h3F};
      tbl[6] = '{1, 1, 2, 1,  50, 100, 1, 40, 2, -1, -1};
      tbl[7] = '{0, 1, 4, 1,  70,  60, 0, 64, 2, -1, -1};

      @(negedge clk);
      @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of a frame, then confirm the FSM stays idle.
      push_words(0, 2, 1'b1);
      start_s[0] = 1'b1;
      tick();
      for (int n = 0; n < 200 && m_cnt[0] < 10; n++) tick();
      chk("pre_reset_cnt0", m_cnt[0], 10);
      rst_n = 1'b0;
      #1 chk_zero("mid_reset");
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0; m_done[k] = 1'b0; m_cnt[k] = 0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) tick();
      fifo[0].delete();

      for (int i = 0; i < 8; i++) run_frame(tbl[i]);

      // Mid-frame start is ignored; abort after 17 samples leaves the FIFO intact.
      fifo[1].delete();
      seq = 8'h00;
      push_words(1, 3, 1'b0);
      rdy_pct[1] = 100; vld_pct[1] = 100; gap_left[1] = 0;
      start_s[1] = 1'b1;
      tick();
      for (int n = 0; n < 100 && m_cnt[1] < 5; n++) tick();
      start_s[1] = 1'b1;
      tick();
      for (int n = 0; n < 100 && m_cnt[1] < 17; n++) tick();
      chk("pre_abort_cnt1", m_cnt[1], 17);
      abort_s[1] = 1'b1;
      tick();
      tick();
      chk("abort_busy1", busy_s[1], 1'b0);
      tick();
      chk("abort_fifo_left1", fifo[1].size(), 2);

      // start together with abort while idle: abort wins.
      start_s[1] = 1'b1;
      abort_s[1] = 1'b1;
      tick();
      tick();
      chk("idle_abort_busy1", busy_s[1], 1'b0);
      chk("idle_abort_fifo1", fifo[1].size(), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
